product_bcd_display: RTL and testbench
======================================

// Module: product_bcd_display
// PURPOSE
//   Downstream stage of the 4-bit sequential multiplier. Detects the rising edge of
//   its done flag and captures the binary product. Converts it to BCD by iterative
//   double-dabble, one bit per clock. Drives active-low 7-segment patterns for the
//   DE10-Lite HEX displays, with leading-zero blanking.
// PARAMETERS
//   BIN_WIDTH  8  width of binary input (product width)
//   DIGITS     3  BCD digits produced; elaboration error unless 10**DIGITS > 2**BIN_WIDTH
// PORTS
//   clk_i    in   1              single clock; all state changes on rising edge
//   rst_i    in   1              synchronous, active-low reset
//   done_i   in   1              multiplier done flag (level); rising edge starts conversion
//   bin_i    in   BIN_WIDTH      multiplier product Y; sampled on the start edge only
//   busy_o   out  1              high while a conversion is in progress (state != S_IDLE)
//   valid_o  out  1              one-cycle pulse: new bcd_o/seg_o result available
//   bcd_o    out  4*DIGITS       packed BCD result, digit0 = bits[3:0]; held until next result
//   seg_o    out  7*DIGITS       active-low segments per digit, {g,f,e,d,c,b,a}; digit0 = bits[6:0]
// BEHAVIOUR
//   Reset (rst_i==0 at an edge), overriding everything:
//     state=S_IDLE, busy_o=0, valid_o=0, bcd_o=0, shift/count regs=0, done_q=1.
//     seg_o: digit0 shows '0' (7'b1000000); all higher digits blank (7'b1111111).
//     done_q=1 means a done_i already high at reset release does not start a conversion.
//   Start: in S_IDLE at an edge with done_i==1 && done_q==0:
//     scratch={zeros,bin_i}, cnt=0, state<=S_SHIFT.
//     done_q<=done_i every non-reset edge, in every state.
//   S_SHIFT, each edge:
//     every BCD nibble of scratch >=5 gets +3; then the whole scratch shifts left 1; cnt++.
//     at the edge where cnt==BIN_WIDTH-1: state<=S_DONE.
//   S_DONE, one edge:
//     bcd_o<=BCD part of scratch; seg_o<=decode(new bcd); valid_o<=1; state<=S_IDLE.
//   valid_o is 1 for exactly one cycle.
//   Latency: valid_o is set by edge capture+BIN_WIDTH+1 (9 edges for the default).
//   Start edges arriving while busy are ignored, not queued; done_q still tracks.
//   done_i held high causes exactly one conversion.
//   Decode: BCD 0-9 uses standard active-low patterns; nibble >9 is impossible,
//     decode to blank.
//   Blanking: digit i>0 is blank iff it and all digits above it are 0.
//     digit0 is never blanked.
//   seg_o and bcd_o update on the same edge, so they are always consistent.
//   Reset mid-conversion: aborts it; no valid_o pulse; outputs return to reset values.
//   Max input 2**BIN_WIDTH-1 (255 -> 0x255); no overflow is possible given the DIGITS check.
// TESTING
//   1. bin_i=8'hE1 (15*15), done_i 0->1:
//      busy_o next cycle; valid_o pulse 9 edges after capture; bcd_o=12'h225;
//      seg_o={2,2,5} patterns.
//   2. bin_i=0, start:
//      bcd_o=12'h000; seg_o digit2, digit1 = 7'h7F; digit0 = 7'b1000000.
//   3. bin_i=8'd7 then bin_i=8'd100, back-to-back starts after each valid_o:
//      first gives bcd 0x007, digits 2,1 blank, digit0 = 7'b1111000;
//      second gives 0x100, middle '0' shown (not blanked).
//   4. done_i held high 30 cycles with bin_i changing:
//      exactly one valid_o; result uses bin_i sampled at the rising edge.
//      A second 0->1 while busy_o=1 is ignored.
//   5. rst_i=0 for one edge at cnt==4, done_i high throughout:
//      busy_o=0, bcd_o=0, no valid_o. No conversion until done_i falls and rises again.
//   6. Exhaustive 0..255, each after the previous valid_o:
//      bcd_o equals decimal value; busy_o low between conversions.

Source files
------------

// File: rtl/product_bcd_display.sv
// Captures the multiplier product on the rising edge of done_i and converts it to BCD by
// double-dabble, one bit per clock. Drives blanked active-low 7-segment patterns.
module product_bcd_display #(
  parameter int unsigned BIN_WIDTH = 8,
  parameter int unsigned DIGITS    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  done_i,
  input  logic [BIN_WIDTH-1:0]  bin_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ScrW = BcdW + BIN_WIDTH;
  localparam int unsigned CntW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BIN_WIDTH - 1);
  // Reset display: digit0 shows '0', every higher digit blank.
  localparam logic [7*DIGITS-1:0] SegReset = {{(7 * DIGITS - 7){1'b1}}, 7'b1000000};

  if (10 ** DIGITS <= 2 ** BIN_WIDTH) begin : g_digits_check
    $error("DIGITS too small to hold every BIN_WIDTH-bit value");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ScrW-1:0]        scratch_q, scratch_d, adjusted;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   done_q;
  logic                   valid_q;
  logic [BcdW-1:0]        bcd_q, bcd_new;
  logic [7*DIGITS-1:0]    seg_q, seg_d;
  logic [3:0]             nib;
  logic                   upper_zero;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Add-3 correction on every BCD nibble ahead of the shift.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[BIN_WIDTH + 4*i +: 4] >= 4'd5) begin
        adjusted[BIN_WIDTH + 4*i +: 4] = scratch_q[BIN_WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (done_i && !done_q) begin
          scratch_d = {{BcdW{1'b0}}, bin_i};
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        scratch_d = {adjusted[ScrW-2:0], 1'b0};
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Leading-zero blanking: scan from the top digit down; digit0 is always shown.
  always_comb begin
    bcd_new    = scratch_q[ScrW-1:BIN_WIDTH];
    seg_d      = '0;
    nib        = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nib = bcd_new[4*i +: 4];
      if (nib != 4'd0) begin
        upper_zero = 1'b0;
      end
      if (i > 0 && upper_zero) begin
        seg_d[7*i +: 7] = 7'b1111111;
      end else begin
        seg_d[7*i +: 7] = seg7(nib);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      scratch_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      seg_q     <= SegReset;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      done_q    <= done_i;
      valid_q   <= (state_q == StDone);
      if (state_q == StDone) begin
        bcd_q <= bcd_new;
        seg_q <= seg_d;
      end
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
  assign seg_o   = seg_q;

endmodule

// File: tb/tb_product_bcd_display.sv
// Randomised and directed bench for product_bcd_display; a timing/arithmetic model
// of the expected outputs is compared against the DUT on every cycle.
module tb_product_bcd_display;

  localparam int Lat = 9;  // edges from capture to result

  logic        clk_i;
  logic        rst_i;
  logic        done_i;
  logic [7:0]  bin_i;
  logic        busy_o;
  logic        valid_o;
  logic [11:0] bcd_o;
  logic [20:0] seg_o;

  product_bcd_display #(
    .BIN_WIDTH(8),
    .DIGITS   (3)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .done_i (done_i),
    .bin_i  (bin_i),
    .busy_o (busy_o),
    .valid_o(valid_o),
    .bcd_o  (bcd_o),
    .seg_o  (seg_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  localparam logic [6:0] SegTab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic logic [11:0] exp_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] exp_seg(input int v);
    logic [20:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0 && v < p) r[7*i +: 7] = 7'h7F;
      else                r[7*i +: 7] = SegTab[(v / p) % 10];
      p = p * 10;
    end
    return r;
  endfunction

  // Reference model: a start begins a fixed-length countdown; the result appears when it expires.
  int          m_timer;
  int          m_pend;
  logic        m_dprev;
  logic        m_valid;
  logic [11:0] m_bcd;
  logic [20:0] m_seg;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      m_timer <= 0;
      m_pend  <= 0;
      m_dprev <= 1'b1;
      m_valid <= 1'b0;
      m_bcd   <= '0;
      m_seg   <= exp_seg(0);
    end else begin
      m_dprev <= done_i;
      m_valid <= 1'b0;
      if (m_timer > 0) begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_valid <= 1'b1;
          m_bcd   <= exp_bcd(m_pend);
          m_seg   <= exp_seg(m_pend);
        end
      end else if (done_i && !m_dprev) begin
        m_timer <= Lat;
        m_pend  <= int'(bin_i);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output against the model.
  task automatic tick();
    @(negedge clk_i);
    if (chk_en) begin
      check("busy",  busy_o,  m_timer != 0);
      check("valid", valid_o, m_valid);
      check("bcd",   bcd_o,   m_bcd);
      check("seg",   seg_o,   m_seg);
    end
  endtask

  task automatic run_conv(input logic [7:0] v, output int lat);
    tick();
    bin_i  = v;
    done_i = 1'b1;
    lat    = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (valid_o) begin
        lat = k;
        break;
      end
    end
    done_i = 1'b0;
  endtask

  initial begin
    int lat;
    int vcount;
    rst_i  = 1'b0;
    done_i = 1'b1;
    bin_i  = 8'd0;
    chk_en = 1'b1;
    tick();
    tick();
    check("rst_busy",  busy_o,  1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_bcd",   bcd_o,   12'h000);
    check("rst_seg",   seg_o,   {7'h7F, 7'h7F, 7'h40});

    // done_i already high at reset release must not start a conversion
    rst_i = 1'b1;
    repeat (3) tick();
    check("no_start_high", busy_o, 1'b0);
    done_i = 1'b0;
    tick();

    run_conv(8'hE1, lat);
    check("lat_e1", lat, 10);
    check("bcd_e1", bcd_o, 12'h225);
    check("seg_e1", seg_o, {7'h24, 7'h24, 7'h12});
    tick();
    check("valid_one_cycle", valid_o, 1'b0);

    run_conv(8'd0, lat);
    check("bcd_0", bcd_o, 12'h000);
    check("seg_0", seg_o, {7'h7F, 7'h7F, 7'h40});

    run_conv(8'd7, lat);
    check("bcd_7", bcd_o, 12'h007);
    check("seg_7", seg_o, {7'h7F, 7'h7F, 7'h78});
    run_conv(8'd100, lat);
    check("bcd_100", bcd_o, 12'h100);
    check("seg_100", seg_o, {7'h79, 7'h40, 7'h40});

    // done_i held high with bin_i changing; a re-rise while busy is ignored
    vcount = 0;
    tick();
    bin_i  = 8'd42;
    done_i = 1'b1;
    tick();
    bin_i = 8'($urandom);
    tick();
    done_i = 1'b0;
    bin_i  = 8'($urandom);
    tick();
    done_i = 1'b1;
    for (int k = 0; k < 27; k++) begin
      tick();
      if (valid_o) vcount++;
      bin_i = 8'($urandom);
    end
    check("held_one_valid", vcount, 1);
    check("held_bcd", bcd_o, 12'h042);
    done_i = 1'b0;
    repeat (3) tick();

    // reset one edge at cnt==4 with done_i high throughout
    vcount = 0;
    tick();
    bin_i  = 8'd199;
    done_i = 1'b1;
    repeat (5) tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid_o) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_bcd", bcd_o, 12'h000);
    check("abort_seg", seg_o, {7'h7F, 7'h7F, 7'h40});
    done_i = 1'b0;
    tick();

    for (int v = 0; v < 256; v++) begin
      check("idle_between", busy_o, 1'b0);
      run_conv(8'(v), lat);
      check("exh_lat", lat, 10);
      check("exh_bcd", bcd_o, exp_bcd(v));
    end

    // free-running random done_i/bin_i traffic, checked by the model every cycle
    for (int k = 0; k < 600; k++) begin
      tick();
      if ($urandom_range(0, 3) == 0) done_i = ~done_i;
      bin_i = 8'($urandom);
      if ($urandom_range(0, 150) == 0) rst_i = 1'b0;
      else                             rst_i = 1'b1;
    end
    rst_i  = 1'b1;
    done_i = 1'b0;
    repeat (15) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
